// File: rtl/data_mem_access_pkg.sv
// Shared types and constants for the data-memory access controller.
package data_mem_access_pkg;

    // Datapath word width used throughout the core.
    localparam int MA_INTERNAL_BITS = 16;

    typedef enum logic [1:0] {
        MA_IDLE  = 2'd0,
        MA_READ  = 2'd1,
        MA_WRITE = 2'd2
    } ma_state_e;

endpackage

// File: rtl/data_mem_addr_gen.sv
// Burst address register and beat down-counter shared by the read and write paths.
module data_mem_addr_gen #(
    parameter int ADDR_BITS = 13,
    parameter int LEN_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [LEN_BITS-1:0]  load_len,
    input  logic                 step,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 cnt_zero
);

    logic [ADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]  cnt_q;

    // Address wraps naturally at 2^ADDR_BITS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            addr_q <= load_addr;
            cnt_q  <= load_len;
        end else if (step) begin
            addr_q <= addr_q + ADDR_BITS'(1);
            if (cnt_q != '0)
                cnt_q <= cnt_q - LEN_BITS'(1);
        end
    end

    assign addr     = addr_q;
    assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/data_mem_access.sv
// Burst read/write controller for the single-address data memory; the memory's
// registered Data_out doubles as the read response holding register.
module data_mem_access
    import data_mem_access_pkg::*;
#(
    parameter int ADDR_BITS = 13,
    parameter int DATA_BITS = MA_INTERNAL_BITS,
    parameter int LEN_BITS  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [LEN_BITS-1:0]  req_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_last,
    output logic                 busy,
    output logic                 mem_Read_enable,
    output logic                 mem_Write_enable,
    output logic [ADDR_BITS-1:0] mem_Address,
    output logic [DATA_BITS-1:0] mem_Write_data,
    input  logic [DATA_BITS-1:0] mem_Data_out
);

    ma_state_e            state_q, state_d;
    logic                 pend_q, last_q;
    logic                 load, step, cnt_zero;
    logic [ADDR_BITS-1:0] addr_q;

    data_mem_addr_gen #(
        .ADDR_BITS(ADDR_BITS),
        .LEN_BITS (LEN_BITS)
    ) u_addr_gen (
        .clk      (CLK),
        .rst      (RST),
        .load     (load),
        .load_addr(req_addr),
        .load_len (req_len),
        .step     (step),
        .addr     (addr_q),
        .cnt_zero (cnt_zero)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_q <= MA_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        wr_ready         = 1'b0;
        mem_Read_enable  = 1'b0;
        mem_Write_enable = 1'b0;
        load             = 1'b0;
        step             = 1'b0;
        case (state_q)
            MA_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load    = 1'b1;
                    state_d = req_write ? MA_WRITE : MA_READ;
                end
            end
            MA_WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    mem_Write_enable = 1'b1;
                    step             = 1'b1;
                    if (cnt_zero)
                        state_d = MA_IDLE;
                end
            end
            MA_READ: begin
                // A new read would overwrite Data_out, so wait until the held beat is taken.
                if (!pend_q || rd_ready) begin
                    mem_Read_enable = 1'b1;
                    step            = 1'b1;
                    if (cnt_zero)
                        state_d = MA_IDLE;
                end
            end
            default: state_d = MA_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q <= 1'b0;
            last_q <= 1'b0;
        end else if (mem_Read_enable) begin
            pend_q <= 1'b1;
            last_q <= cnt_zero;
        end else if (rd_ready) begin
            pend_q <= 1'b0;
        end
    end

    assign rd_valid       = pend_q;
    assign rd_data        = mem_Data_out;
    assign rd_last        = pend_q & last_q;
    assign busy           = (state_q != MA_IDLE) | pend_q;
    assign mem_Address    = addr_q;
    assign mem_Write_data = wr_data;

endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: behavioural registered memory, burst vector table,
// write/read scoreboards, plus hand-driven backpressure and mid-burst reset.
module tb_data_mem_access;

    localparam int AW = 13;
    localparam int DW = 16;
    localparam int LW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_valid = 1'b0, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_ready = 1'b1;
    logic          req_ready, wr_ready, rd_valid, rd_last, busy;
    logic [DW-1:0] rd_data, mem_Write_data, mem_Data_out;
    logic          mem_Read_enable, mem_Write_enable;
    logic [AW-1:0] mem_Address;

    always #5 CLK = ~CLK;

    data_mem_access dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy),
        .mem_Read_enable(mem_Read_enable), .mem_Write_enable(mem_Write_enable),
        .mem_Address(mem_Address), .mem_Write_data(mem_Write_data),
        .mem_Data_out(mem_Data_out)
    );

    // Memory model: write lands at the edge, Data_out registered on Read_enable.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] dout_q = '0;
    always @(posedge CLK) begin
        if (mem_Write_enable) mem[mem_Address] <= mem_Write_data;
        if (mem_Read_enable)  dout_q <= mem[mem_Address];
    end
    assign mem_Data_out = dout_q;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } rd_exp_t;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];

    always @(negedge CLK) begin
        if (mem_Write_enable) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", 32'(mem_Address), 32'hFFFF_FFFF);
            end else begin
                wr_exp_t e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(mem_Address), 32'(e.addr));
                check("wr_data", 32'(mem_Write_data), 32'(e.data));
                check("wr_excl_re", 32'(mem_Read_enable), 32'd0);
            end
        end
        if (rd_valid && rd_ready) begin
            if (rd_q.size() == 0) begin
                check("unexpected_read", 32'(rd_data), 32'hFFFF_FFFF);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(e.data));
                check("rd_last", 32'(rd_last), 32'(e.last));
            end
        end
    end

    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [DW-1:0] d0;
        logic [DW-1:0] dstep;
        int            stall_beat;
        int            stall_cyc;
    } vec_t;

    task automatic issue_req(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n;
        n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
        while (!req_ready && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        check("req_accept_timeout", 32'(n < 50), 32'd1);
        @(posedge CLK); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_write(input vec_t v);
        issue_req(1'b1, v.addr, v.len);
        for (int i = 0; i <= int'(v.len); i++) begin
            int n;
            wr_exp_t e;
            n = 0;
            wr_valid = 1'b1;
            wr_data  = 16'(v.d0 + i * v.dstep);
            while (!wr_ready && n < 50) begin
                @(posedge CLK); #1; n++;
            end
            e.addr = 13'(v.addr + i);
            e.data = wr_data;
            wr_q.push_back(e);
            @(posedge CLK); #1;
        end
        wr_valid = 1'b0;
        #1;
        check("wr_end_busy", 32'(busy), 32'd0);
        check("wr_end_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic do_read(input vec_t v);
        int cyc, beats, stall_left;
        for (int i = 0; i <= int'(v.len); i++) begin
            rd_exp_t e;
            e.data = 16'(v.d0 + i * v.dstep);
            e.last = (i == int'(v.len));
            rd_q.push_back(e);
        end
        issue_req(1'b0, v.addr, v.len);
        cyc = 0; beats = 0; stall_left = v.stall_cyc;
        while (beats <= int'(v.len) && cyc < 300) begin
            if (cyc == 0)
                check("rd_first_issue", {30'd0, rd_valid, mem_Read_enable}, 32'd1);
            if (rd_valid && beats == v.stall_beat && stall_left > 0) begin
                rd_ready = 1'b0;
                stall_left--;
                #1;
                check("stall_hold_data", 32'(rd_data), 32'(16'(v.d0 + v.stall_beat * v.dstep)));
                check("stall_no_re", 32'(mem_Read_enable), 32'd0);
            end else begin
                rd_ready = 1'b1;
            end
            if (rd_valid && rd_ready) beats++;
            @(posedge CLK); #1;
            cyc++;
        end
        rd_ready = 1'b1;
        check("rd_cycles", 32'(cyc), 32'(int'(v.len) + 2 + v.stall_cyc));
    endtask

    vec_t vecs[8];

    initial begin
        int n, iss;
        vec_t tail;

        vecs[0] = '{1'b1, 13'h0010, 8'd3, 16'h00A0, 16'h0001, -1, 0};
        vecs[1] = '{1'b0, 13'h0010, 8'd3, 16'h00A0, 16'h0001, -1, 0};
        vecs[2] = '{1'b0, 13'h0010, 8'd3, 16'h00A0, 16'h0001,  1, 3};
        vecs[3] = '{1'b1, 13'h1FFF, 8'd1, 16'h0055, 16'h0011, -1, 0};
        vecs[4] = '{1'b0, 13'h1FFF, 8'd1, 16'h0055, 16'h0011, -1, 0};
        vecs[5] = '{1'b1, 13'h0020, 8'd0, 16'h0077, 16'h0000, -1, 0};
        vecs[6] = '{1'b0, 13'h0020, 8'd0, 16'h0077, 16'h0000, -1, 0};
        vecs[7] = '{1'b1, 13'h0100, 8'd7, 16'h00B0, 16'h0001, -1, 0};

        repeat (3) @(posedge CLK);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_outputs", {26'd0, wr_ready, rd_valid, rd_last, busy, mem_Read_enable, mem_Write_enable}, 32'd0);
        check("rst_addr", 32'(mem_Address), 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        foreach (vecs[k]) begin
            if (vecs[k].write) do_write(vecs[k]);
            else               do_read(vecs[k]);
        end

        // Reset in the middle of an 8-beat read, after the third issue.
        rd_q.push_back('{16'h00B0, 1'b0});
        rd_q.push_back('{16'h00B1, 1'b0});
        issue_req(1'b0, 13'h0100, 8'd7);
        rd_ready = 1'b1;
        n = 0; iss = 0;
        while (iss < 3 && n < 20) begin
            if (mem_Read_enable) iss++;
            @(posedge CLK); #1; n++;
        end
        check("mid_rst_issues", 32'(iss), 32'd3);
        RST = 1'b1;
        #1;
        check("mid_rst_outputs", {28'd0, rd_valid, mem_Read_enable, mem_Write_enable, busy}, 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;

        tail = '{1'b0, 13'h0100, 8'd7, 16'h00B0, 16'h0001, 3, 2};
        do_read(tail);

        repeat (2) @(posedge CLK);
        #1;
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_mem_access.md
Name: data_mem_access

Overview:
- Initiator-side controller that owns the single-address, two-port data memory.
- Accepts single or burst read/write requests from the datapath and generates sequential addresses.
- Drives the memory's Read_enable/Write_enable/Address/Write_data.
- Returns read data with a valid/ready handshake, using the memory's registered Data_out as the response holding register.

Parameters:
- ADDR_BITS, 13, memory address width; addresses wrap modulo 2^ADDR_BITS.
- DATA_BITS, `INTERNAL_BITS (def.v), data word width.
- LEN_BITS, 8, burst length field width; a request covers req_len+1 beats.

Ports:
- CLK  in  1  single clock; memory CLKA and CLKB are both tied to CLK at top level.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid&req_ready.
- req_write  in  1  1=write burst, 0=read burst.
- req_addr  in  ADDR_BITS  burst start address.
- req_len  in  LEN_BITS  beats minus one.
- wr_valid  in  1  write beat data present.
- wr_ready  out  1  write beat accepted.
- wr_data  in  DATA_BITS  write beat data.
- rd_valid  out  1  read beat available.
- rd_ready  in  1  read beat consumed.
- rd_data  out  DATA_BITS  read beat data; equals mem_Data_out.
- rd_last  out  1  final beat of the read burst.
- busy  out  1  state!=IDLE or a read beat is pending.
- mem_Read_enable  out  1  to memory Read_enable.
- mem_Write_enable  out  1  to memory Write_enable.
- mem_Address  out  ADDR_BITS  to memory Address.
- mem_Write_data  out  DATA_BITS  to memory Write_data.
- mem_Data_out  in  DATA_BITS  from memory Data_out.

Behaviour:
- Reset values (asynchronous): state=IDLE, addr_q=0, cnt_q=0, pend_q=0, last_q=0, so req_ready=1, wr_ready=0, rd_valid=0, rd_last=0, busy=0, both mem enables=0, mem_Address=0.
- FSM states: IDLE, READ, WRITE.
- IDLE: req_ready=1.
  - On accept, addr_q<=req_addr, cnt_q<=req_len, next state READ or WRITE per req_write.
  - No memory access is issued in the accept cycle.
- WRITE:
  - wr_ready=1.
  - mem_Write_enable = wr_valid (combinational); mem_Address=addr_q; mem_Write_data=wr_data.
  - On each beat, addr_q<=addr_q+1 (wraps 2^ADDR_BITS-1 -> 0).
  - If cnt_q==0, go to IDLE; else cnt_q<=cnt_q-1.
  - wr_valid low: no access, no state change.
- READ:
  - issue = !pend_q | rd_ready.
  - mem_Read_enable = issue; mem_Address=addr_q.
  - On issue: pend_q<=1, last_q<=(cnt_q==0), addr_q increments and wraps.
  - On the last issue (cnt_q==0), go to IDLE; else cnt_q<=cnt_q-1.
- Read response:
  - rd_valid=pend_q; rd_data=mem_Data_out; rd_last=pend_q&last_q.
  - Read latency is 1 cycle: issue at edge t gives rd_valid from t until consumed.
  - When rd_ready=0, Read_enable stays low, so memory Data_out holds and rd_data stays stable.
  - A consume with no new issue clears pend_q.
  - Full throughput is 1 beat/cycle with rd_ready held high.
- Pending read at burst end:
  - The FSM may return to IDLE and accept a new request while pend_q=1.
  - A following write may issue immediately; Data_out is unaffected by writes.
  - A following read may not issue until the pending beat is consumed (the issue rule).
- Read-after-write to the same address in consecutive cycles returns the new data. The write lands at edge t and the read samples at edge t+1; no bypass is needed.
- mem_Read_enable and mem_Write_enable are never both 1.
- mem_Address=addr_q whenever an enable is high; it is don't-care otherwise but is driven as addr_q.
- Reset mid-burst: immediate return to reset values. The remaining beats and any pending read beat are discarded, and no enable is asserted after RST rises.
- req_len is LEN_BITS wide and unsigned; the maximum burst is 2^LEN_BITS beats.

Decomposition:
- Shared package/def.v:
  - `INTERNAL_BITS (existing).
  - State encodings MA_IDLE=2'd0, MA_READ=2'd1, MA_WRITE=2'd2.
- No sub-module is required.
- Optional sub-module data_mem_addr_gen (address register + beat down-counter + last flag), shared by the READ and WRITE paths.

Test Plan:
- Write burst: req addr=0x010, len=3, write=1, then wr_data 0xA0..0xA3 back-to-back -> Write_enable for 4 cycles at 0x010..0x013; busy drops and IDLE follows the 4th beat.
- Read burst: req addr=0x010, len=3, rd_ready=1 -> rd_valid for 4 consecutive cycles with 0xA0..0xA3, first beat 1 cycle after the first Read_enable, rd_last only on 0xA3.
- Read backpressure: same read with rd_ready low for 3 cycles on beat 1 -> rd_data holds 0xA1, no Read_enable during the stall, then 0xA2, 0xA3 resume.
- Wrap: write len=1 at addr=0x1FFF with 0x55, 0x66 -> writes to 0x1FFF and 0x0000; read-back returns 0x55, 0x66.
- RAW: single write 0x77 @0x020 immediately followed by a single read @0x020 -> rd_data=0x77.
- Reset mid read burst (len=7, RST after beat 2 issued) -> rd_valid=0 and enables=0 asynchronously, req_ready=1; a new request after RST falls completes normally.
